// File: rtl/imem_sync_fetch.sv
// Synchronous instruction memory with a valid/ready fetch port, a LATENCY-deep
// response pipeline, a word-load port and a saturating fault counter.
module imem_sync_fetch #(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DEPTH     = 64,
  parameter int unsigned       LATENCY   = 2,
  parameter logic [DATA_W-1:0] INIT_WORD = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     rsp_fault,
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [DATA_W-1:0]        ld_data,
  output logic [7:0]               fault_cnt
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  // Storage holds word ^ INIT_WORD so that cells that come up cleared read as
  // INIT_WORD, and reset never has to touch the array.
  logic [DATA_W-1:0]  mem_q [DEPTH];

  logic [LATENCY-1:0] pv_q;
  logic [LATENCY-1:0] pf_q;
  logic [DATA_W-1:0]  pd_q [LATENCY];
  logic [LATENCY-1:0] adv_c;
  logic [7:0]         fault_cnt_q;

  logic               accept_c;
  logic               fault_c;
  logic [IDX_W-1:0]   idx_c;
  logic [DATA_W-1:0]  rdata_c;

  // Stage i may load this edge if it, or any stage after it, has room or the
  // output is being consumed; this also collapses bubbles.
  always_comb begin
    logic hole;
    hole  = rsp_ready;
    adv_c = '0;
    for (int i = int'(LATENCY) - 1; i >= 0; i--) begin
      hole     = hole | ~pv_q[i];
      adv_c[i] = hole;
    end
  end

  // Request decode: range check uses the full address, read is skipped on fault.
  always_comb begin
    idx_c     = req_addr[IDX_W+1:2];
    fault_c   = (req_addr[1:0] != 2'b00) || ((req_addr >> 2) >= ADDR_W'(DEPTH));
    rdata_c   = fault_c ? '0 : (mem_q[idx_c] ^ INIT_WORD);
    req_ready = ~reset & ~ld_en & adv_c[0];
    accept_c  = req_valid & req_ready;
  end

  // Load port write; contents survive reset.
  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem_q[ld_addr] <= ld_data ^ INIT_WORD;
    end
  end

  // Response pipeline: stage 0 captures the read at accept, later stages shift.
  always_ff @(posedge clk) begin
    if (reset) begin
      pv_q <= '0;
      pf_q <= '0;
      for (int i = 0; i < int'(LATENCY); i++) begin
        pd_q[i] <= '0;
      end
    end else begin
      if (adv_c[0]) begin
        pv_q[0] <= accept_c;
        pf_q[0] <= accept_c & fault_c;
        pd_q[0] <= accept_c ? rdata_c : '0;
      end
      for (int i = 1; i < int'(LATENCY); i++) begin
        if (adv_c[i]) begin
          pv_q[i] <= pv_q[i-1];
          pf_q[i] <= pf_q[i-1];
          pd_q[i] <= pd_q[i-1];
        end
      end
    end
  end

  // Saturating count of faulted responses taken by the consumer.
  always_ff @(posedge clk) begin
    if (reset) begin
      fault_cnt_q <= '0;
    end else if (rsp_valid && rsp_ready && rsp_fault && (fault_cnt_q != 8'hFF)) begin
      fault_cnt_q <= fault_cnt_q + 8'd1;
    end
  end

  assign rsp_valid = pv_q[LATENCY-1];
  assign rsp_fault = pf_q[LATENCY-1];
  assign rsp_data  = pd_q[LATENCY-1];
  assign fault_cnt = fault_cnt_q;

endmodule
